// File: rtl/count_cmd_controller.sv
// Command decoder that turns SPI command words into per-channel count gates (free-running or timed).
// Optional build macro STATUS_READBACK_EN adds a registered STATUS word and the CLR_STATUS opcode.

//  state     | meaning
//  IDLE      | no window open, all gates low
//  RUN_FREE  | gates open until STOP or a new START
//  RUN_TIMED | gates open while timer counts down from gate_len
module count_cmd_controller #(
  parameter int          CMD_W      = 32,
  parameter int          N_CH       = 4,
  parameter int          TIMER_W    = 16,
  parameter logic [31:0] START_CODE = 32'hFFFF_FFFF,
  parameter logic [31:0] STOP_CODE  = 32'h1111_1111
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [CMD_W-1:0] rx,
  input  logic             rxValid,
  output logic [N_CH-1:0]  COUNT_SIG,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
`ifdef STATUS_READBACK_EN
  ,
  output logic [CMD_W-1:0] STATUS
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_FREE  = 2'd1,
    RUN_TIMED = 2'd2
  } state_t;

  localparam logic [CMD_W-1:0] START_W = CMD_W'(START_CODE);
  localparam logic [CMD_W-1:0] STOP_W  = CMD_W'(STOP_CODE);

  state_t             state;
  logic               vld_meta;
  logic               vld_sync;
  logic               vld_prev;
  logic               cmd_vld;
  logic [CMD_W-1:0]   cmd_q;
  logic [TIMER_W-1:0] gate_len;
  logic [TIMER_W-1:0] timer;

  logic [7:0]         opcode;
  logic [N_CH-1:0]    mask_eff;
  logic [TIMER_W-1:0] arg;
  logic [N_CH-1:0]    new_mask;
  logic               do_free;
  logic               do_timed;
  logic               do_stop;
  logic               do_len;
  logic               do_err;
`ifdef STATUS_READBACK_EN
  logic               do_clr;
  logic               err_sticky;
  logic [7:0]         mask_ext;
`endif

  // rxValid is asynchronous: synchronise, then act only on its rising edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_meta <= 1'b0;
      vld_sync <= 1'b0;
      vld_prev <= 1'b0;
      cmd_vld  <= 1'b0;
      cmd_q    <= '0;
    end else begin
      vld_meta <= rxValid;
      vld_sync <= vld_meta;
      vld_prev <= vld_sync;
      cmd_vld  <= vld_sync & ~vld_prev;
      if (vld_sync & ~vld_prev) cmd_q <= rx;
    end
  end

  assign opcode   = cmd_q[CMD_W-1 -: 8];
  assign mask_eff = cmd_q[CMD_W-16 +: N_CH];
  assign arg      = cmd_q[TIMER_W-1:0];

  always_comb begin
    do_free  = 1'b0;
    do_timed = 1'b0;
    do_stop  = 1'b0;
    do_len   = 1'b0;
    do_err   = 1'b0;
    new_mask = mask_eff;
`ifdef STATUS_READBACK_EN
    do_clr   = 1'b0;
`endif
    if (cmd_vld) begin
      if (cmd_q == START_W) begin
        do_free  = 1'b1;
        new_mask = '1;
      end else if (cmd_q == STOP_W) begin
        do_stop = 1'b1;
      end else begin
        case (opcode)
          8'h00: ;
          8'h01: begin
            if (mask_eff == '0) do_err  = 1'b1;
            else                do_free = 1'b1;
          end
          8'h02: do_stop = 1'b1;
          8'h03: do_len  = 1'b1;
          8'h04: begin
            // a zero length would never expire, so it is rejected like an empty mask
            if (mask_eff == '0 || gate_len == '0) do_err   = 1'b1;
            else                                  do_timed = 1'b1;
          end
`ifdef STATUS_READBACK_EN
          8'h05: do_clr = 1'b1;
`endif
          default: do_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      COUNT_SIG <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      gate_len  <= '0;
      timer     <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= do_err;
      if (do_len) gate_len <= arg;
      // a start/stop decoded on the expiry cycle wins over the expiry
      if (do_free) begin
        state     <= RUN_FREE;
        COUNT_SIG <= new_mask;
        BUSY      <= 1'b1;
        timer     <= '0;
      end else if (do_timed) begin
        state     <= RUN_TIMED;
        COUNT_SIG <= new_mask;
        BUSY      <= 1'b1;
        timer     <= gate_len;
      end else if (do_stop) begin
        state     <= IDLE;
        COUNT_SIG <= '0;
        BUSY      <= 1'b0;
        timer     <= '0;
      end else if (state == RUN_TIMED) begin
        if (timer == TIMER_W'(1)) begin
          state     <= IDLE;
          COUNT_SIG <= '0;
          BUSY      <= 1'b0;
          DONE      <= 1'b1;
          timer     <= '0;
        end else if (timer != '0) begin
          timer <= timer - TIMER_W'(1);
        end
      end
    end
  end

`ifdef STATUS_READBACK_EN
  always_comb begin
    mask_ext            = '0;
    mask_ext[N_CH-1:0]  = COUNT_SIG;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_sticky <= 1'b0;
      STATUS     <= '0;
    end else begin
      if (do_clr)      err_sticky <= 1'b0;
      else if (do_err) err_sticky <= 1'b1;
      STATUS <= {state, BUSY, err_sticky, {(CMD_W-12-TIMER_W){1'b0}}, mask_ext, timer};
    end
  end
`endif

endmodule

// File: tb/tb_count_cmd_controller.sv
// Directed plus randomized bench for count_cmd_controller against a window-level reference model.
// STATUS checks are compiled in when STATUS_READBACK_EN is defined.
module tb_count_cmd_controller;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] rx = '0;
  logic        rxValid = 1'b0;
  logic [3:0]  COUNT_SIG;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
`ifdef STATUS_READBACK_EN
  logic [31:0] STATUS;
`endif

  always #5 CLK = ~CLK;

  count_cmd_controller dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rx        (rx),
    .rxValid   (rxValid),
    .COUNT_SIG (COUNT_SIG),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
`ifdef STATUS_READBACK_EN
    ,
    .STATUS    (STATUS)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: mode 0 idle, 1 free window, 2 timed window with cycles left
  int       m_mode, m_left, m_len;
  logic [3:0] m_mask;
  logic     m_sticky, e_done, e_err;
  int       p_left;
  logic     p_sticky, p_busy;
  logic [3:0] p_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_len = 0; m_mask = '0; m_sticky = 1'b0;
    e_done = 1'b0; e_err = 1'b0;
  endtask

  task automatic apply(input logic [31:0] w, output bit changed);
    logic [7:0] opc;
    logic [3:0] m;
    opc = w[31:24];
    m   = w[19:16];
    changed = 1'b0;
    if (w == 32'hFFFF_FFFF) begin
      m_mode = 1; m_mask = 4'hF; m_left = 0; changed = 1'b1;
    end else if (w == 32'h1111_1111) begin
      m_mode = 0; m_mask = '0; m_left = 0; changed = 1'b1;
    end else begin
      case (opc)
        8'h00: ;
        8'h01: if (m == 0) e_err = 1'b1;
               else begin m_mode = 1; m_mask = m; m_left = 0; changed = 1'b1; end
        8'h02: begin m_mode = 0; m_mask = '0; m_left = 0; changed = 1'b1; end
        8'h03: m_len = int'(w[15:0]);
        8'h04: if (m == 0 || m_len == 0) e_err = 1'b1;
               else begin m_mode = 2; m_mask = m; m_left = m_len; changed = 1'b1; end
`ifdef STATUS_READBACK_EN
        8'h05: m_sticky = 1'b0;
`endif
        default: e_err = 1'b1;
      endcase
    end
    if (e_err) m_sticky = 1'b1;
  endtask

  // one clock: advance the model at the rising edge, compare on the falling edge
  task automatic tick(input bit act, input logic [31:0] w);
    bit ch;
    p_left   = (m_mode == 2) ? m_left : 0;
    p_sticky = m_sticky;
    p_busy   = (m_mode != 0);
    p_mask   = m_mask;
    @(posedge CLK);
    e_done = 1'b0; e_err = 1'b0; ch = 1'b0;
    if (act) apply(w, ch);
    if (!ch && m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin m_mode = 0; m_mask = '0; e_done = 1'b1; end
    end
    @(negedge CLK);
    check("count_sig", 32'(COUNT_SIG), 32'(m_mask));
    check("busy", 32'(BUSY), 32'(m_mode != 0));
    check("done", 32'(DONE), 32'(e_done));
    check("err", 32'(ERR), 32'(e_err));
`ifdef STATUS_READBACK_EN
    check("status_sticky", 32'(STATUS[28]), 32'(p_sticky));
    check("status_busy", 32'(STATUS[29]), 32'(p_busy));
    check("status_mask", 32'(STATUS[23:16]), 32'(p_mask));
    check("status_timer", 32'(STATUS[15:0]), p_left);
`endif
  endtask

  // rxValid rises mid-cycle; the command takes effect on the 4th rising edge after that
  task automatic send(input logic [31:0] w, input int hold);
    int n;
    n = (hold > 4) ? hold : 4;
    rx = w;
    rxValid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      if (i == hold + 1) rxValid = 1'b0;
      tick(i == 4, w);
    end
    rxValid = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  initial begin
    logic [31:0] w;
    int kind;
    model_reset();
    #12;
    check("rst_count_sig", 32'(COUNT_SIG), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(3);

    send(32'hFFFF_FFFF, 2);
    idle(3);
    send(32'h1111_1111, 2);
    idle(3);

    send(32'h0300_0064, 2);
    send(32'h0405_0000, 2);
    idle(105);

    send(32'h0405_0000, 2);
    idle(44);
    send(32'h0102_0000, 2);
    idle(120);
    send(32'h0200_0000, 2);

    send(32'h7F00_0000, 2);
    send(32'h01F0_0000, 2);
    send(32'h0300_0000, 2);
    send(32'h0405_0000, 2);
    send(32'h0500_0000, 2);
    idle(3);

    send(32'h0103_0000, 20);
    idle(5);
    send(32'h0200_0000, 2);

    send(32'h0300_0014, 2);
    send(32'h0401_0000, 2);
    idle(5);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_count_sig", 32'(COUNT_SIG), 32'h0);
    check("async_rst_busy", 32'(BUSY), 32'h0);
    check("async_rst_done", 32'(DONE), 32'h0);
    check("async_rst_err", 32'(ERR), 32'h0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(30);

    for (int k = 0; k < 60; k++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: w = 32'hFFFF_FFFF;
        1: w = 32'h1111_1111;
        2: w = {8'h03, 8'($urandom), 16'($urandom_range(0, 30))};
        3, 4: w = {8'h04, 8'($urandom), 16'($urandom)};
        5: w = {8'h01, 8'($urandom), 16'($urandom)};
        6: w = 32'h0200_0000;
        7: w = {8'($urandom_range(0, 7)), 24'($urandom)};
        8: w = $urandom;
        default: w = {8'h00, 24'($urandom)};
      endcase
      send(w, int'($urandom_range(1, 6)));
      idle(int'($urandom_range(0, 25)));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_cmd_controller.md
Name: count_cmd_controller

Overview:
- Parametrised successor to the single-bit count controller. It decodes 32-bit-class command words from the SPI slave into per-channel count-enable gates, using free-running or hardware-timed windows.
- Sits between the SPI receiver (rx word plus rxValid strobe) and the photon counter channels, and returns window-complete and error status to the counter/readout logic.
- Legacy codes FFFF_FFFF (start all) and 1111_1111 (stop all) keep working.

Parameters:
CMD_W, 32, command word width; must be at least 16+TIMER_W
N_CH, 4, number of count channels, 1..8
TIMER_W, 16, gate-length counter width in CLK cycles
START_CODE, 32'hFFFF_FFFF, legacy start-all word (compared on the low 32 bits; the upper bits must be 0)
STOP_CODE, 32'h1111_1111, legacy stop-all word (same comparison rule)

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST_N  in  1  asynchronous active-low reset
rx  in  CMD_W  command word from SPI; stable while rxValid is high
rxValid  in  1  word-valid strobe from the SPI domain (asynchronous to CLK)
COUNT_SIG  out  N_CH  per-channel count enable
BUSY  out  1  high while any window is active
DONE  out  1  one-cycle pulse when a timed window expires
ERR  out  1  one-cycle pulse on an illegal or unknown command

Behaviour:
- Reset (RST_N low, asynchronous): COUNT_SIG=0, BUSY=0, DONE=0, ERR=0, state=IDLE, gate_len=0, timer=0, sync flops=0. Reset mid-window aborts the window with no DONE.
- Input capture:
  - rxValid passes through a 2-flop synchroniser into CLK, then rising-edge detection; rx is sampled into cmd_q on the detected edge.
  - The command acts one cycle later. Total latency from rxValid rise to COUNT_SIG change is 3-4 CLK.
  - One command per rxValid rise; a held-high rxValid gives exactly one command.
- Decode, in this order:
  1. cmd_q==START_CODE: LOAD_FREE with mask=all ones.
  2. cmd_q==STOP_CODE: STOP.
  3. Otherwise, opcode=cmd_q[CMD_W-1:CMD_W-8], mask=cmd_q[CMD_W-9:CMD_W-16], arg=cmd_q[TIMER_W-1:0].
     - Opcode 0x01 START_FREE(mask).
     - Opcode 0x02 STOP.
     - Opcode 0x03 SET_LEN(arg): writes gate_len; legal in any state and does not affect a running window.
     - Opcode 0x04 START_TIMED(mask).
     - Opcode 0x00 NOP.
     - Any other opcode: ERR pulse, no state change.
  - Mask bits at or above N_CH are ignored. An effective mask of 0 on any START: ERR pulse, ignored.
- States:
  - IDLE: COUNT_SIG=0, BUSY=0.
    - START_FREE goes to RUN_FREE, COUNT_SIG=mask.
    - START_TIMED with gate_len==0 gives ERR and stays in IDLE.
    - Otherwise START_TIMED goes to RUN_TIMED, COUNT_SIG=mask, timer=gate_len.
  - RUN_FREE: BUSY=1.
    - STOP goes to IDLE, COUNT_SIG=0.
    - A new START_FREE replaces the mask with no gap cycle.
    - START_TIMED goes to RUN_TIMED, reloads the timer and does not pulse DONE.
  - RUN_TIMED: BUSY=1; timer decrements each CLK.
    - COUNT_SIG stays high for exactly gate_len cycles.
    - When timer reaches 1, the next cycle sets COUNT_SIG=0, BUSY=0, DONE=1 for one cycle and returns to IDLE.
    - STOP goes to IDLE with no DONE.
    - START_* restarts: new mask, timer reloads, no DONE.
- Simultaneous events: a command decoded on the expiry cycle takes priority. The window is treated as restarted or stopped, and DONE is suppressed.
- The timer never wraps: it loads only non-zero values and stops at 0.

Optional Feature:
- Macro: STATUS_READBACK_EN.
- When defined:
  - Adds output STATUS[CMD_W-1:0] = {state[1:0], BUSY, sticky err flag, zero pad, mask[7:0] (upper bits 0 when N_CH<8), timer[TIMER_W-1:0]}, registered and updated every CLK, for the SPI reply path.
  - The sticky err flag is cleared by opcode 0x05 CLR_STATUS.
  - Reset value of STATUS is 0.
- When undefined: no STATUS port, opcode 0x05 is an unknown opcode and raises ERR, and no sticky flag is built.

Test Plan:
- Reset then rx=FFFF_FFFF, pulse rxValid -> COUNT_SIG=4'b1111 within 4 CLK and BUSY=1. Then rx=1111_1111 -> COUNT_SIG=0, BUSY=0, no DONE.
- SET_LEN 100 (0x0300_0064), then START_TIMED mask 0x05 (0x0405_0000) -> COUNT_SIG=4'b0101 for exactly 100 CLK, a single DONE pulse on the cycle COUNT_SIG falls, state returns to IDLE.
- START_TIMED with len 100, then at cycle 50 START_FREE mask 0x02 -> COUNT_SIG=4'b0010 with no gap, no DONE ever; STOP clears it.
- Illegal inputs: opcode 0x7F, START with mask 0xF0 (N_CH=4), START_TIMED with gate_len=0 -> each gives one ERR pulse and COUNT_SIG is unchanged.
- rxValid held high for 20 CLK with START_FREE -> exactly one command executes. Assert RST_N low mid RUN_TIMED -> all outputs 0 asynchronously, no DONE after release.
- With STATUS_READBACK_EN defined: after an illegal command, STATUS sticky err=1; CLR_STATUS (0x0500_0000) -> sticky err=0. During RUN_TIMED, the STATUS timer field decrements by 1 per CLK.
